// File: rtl/bcd_down_counter_timer.sv
// Multi-digit BCD countdown timer: loads a decimal preset, then counts down one
// unit per qualified tick with digit-wise borrow, stopping at zero with a done pulse.
module bcd_down_counter_timer #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t              state, state_nx;
  logic [4*DIGITS-1:0] count_nx;
  logic [4*DIGITS-1:0] dec;
  logic                done_nx, err_nx;
  logic                val_ok, borrow, count_nz;

  always_comb begin
    val_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (load_val[4*i +: 4] > 4'd9) val_ok = 1'b0;
  end

  // Borrow ripples upward and stops at the first nonzero digit.
  always_comb begin
    dec    = count;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
  end

  assign count_nz = (count != '0);

  // Priority: clear, load (not in RUN), pause, start (not in RUN), tick.
  // A load or start that is meaningless in RUN falls through to lower inputs.
  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (clear) begin
      count_nx = '0;
      state_nx = IDLE;
    end else if (load && state != RUN) begin
      if (val_ok) begin
        count_nx = load_val;
        if (state == DONE) state_nx = IDLE;
      end else begin
        err_nx = 1'b1;
      end
    end else if (pause) begin
      if (state == RUN) state_nx = PAUSED;
    end else if (start && state != RUN) begin
      if ((state == IDLE || state == PAUSED) && count_nz) state_nx = RUN;
    end else if (tick && state == RUN) begin
      count_nx = dec;
      if (dec == '0) begin
        state_nx = DONE;
        done_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      done     <= done_nx;
      load_err <= err_nx;
    end
  end

  assign running = (state == RUN);
  assign zero    = ~count_nz;

endmodule

// File: tb/tb_bcd_down_counter_timer.sv
// Directed bench for bcd_down_counter_timer: 2-digit main instance plus a
// 3-digit instance for the multi-digit borrow case.
module tb_bcd_down_counter_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [7:0]  load_val = '0;
  logic [7:0]  count;
  logic        running, zero, done, load_err;

  logic        clear3 = 1'b0, load3 = 1'b0, start3 = 1'b0, pause3 = 1'b0, tick3 = 1'b0;
  logic [11:0] load_val3 = '0;
  logic [11:0] count3;
  logic        running3, zero3, done3, load_err3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_down_counter_timer #(.DIGITS(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick), .count(count), .running(running),
    .zero(zero), .done(done), .load_err(load_err)
  );

  bcd_down_counter_timer #(.DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .clear(clear3), .load(load3), .load_val(load_val3),
    .start(start3), .pause(pause3), .tick(tick3), .count(count3), .running(running3),
    .zero(zero3), .done(done3), .load_err(load_err3)
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (count[3:0] <= 4'd9 && count[7:4] <= 4'd9 && count3[3:0] <= 4'd9 &&
            count3[7:4] <= 4'd9 && count3[11:8] <= 4'd9) else begin
      failures++;
      $error("FAIL digit_legal observed=%h/%h expected=all digits <= 9", count, count3);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    clear3 = 1'b0; load3 = 1'b0; start3 = 1'b0; pause3 = 1'b0; tick3 = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", 16'(count), 16'h00);
    chk("rst_zero", 16'(zero), 16'h1);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_load_err", 16'(load_err), 16'h0);
    #10 reset = 1'b1;
    step();

    // load 25 in IDLE, run to zero
    load = 1'b1; load_val = 8'h25; step();
    chk("load25_count", 16'(count), 16'h25);
    chk("load25_zero", 16'(zero), 16'h0);
    chk("load25_running", 16'(running), 16'h0);
    start = 1'b1; step();
    chk("start_running", 16'(running), 16'h1);
    chk("start_count", 16'(count), 16'h25);
    for (int v = 24; v >= 0; v--) begin
      tick = 1'b1; step();
      chk("down_count", 16'(count), 16'(bcd(v)));
      chk("down_done", 16'(done), (v == 0) ? 16'h1 : 16'h0);
    end
    chk("end_running", 16'(running), 16'h0);
    chk("end_zero", 16'(zero), 16'h1);
    tick = 1'b1; step();
    chk("done_tick_count", 16'(count), 16'h00);
    chk("done_once", 16'(done), 16'h0);

    // borrow across digits: 10 -> 09
    load = 1'b1; load_val = 8'h10; step();
    chk("done_load_idle", 16'(running), 16'h0);
    chk("load10_count", 16'(count), 16'h10);
    start = 1'b1; step();
    tick = 1'b1; step();
    chk("borrow_09", 16'(count), 16'h09);

    // load while RUN is ignored without error
    load = 1'b1; load_val = 8'h05; step();
    chk("run_load_count", 16'(count), 16'h09);
    chk("run_load_err", 16'(load_err), 16'h0);
    chk("run_load_running", 16'(running), 16'h1);

    // pause, load 05 in PAUSED, resume, pause interactions
    pause = 1'b1; step();
    chk("paused_running", 16'(running), 16'h0);
    load = 1'b1; load_val = 8'h05; step();
    chk("paused_load_count", 16'(count), 16'h05);
    chk("paused_load_stays", 16'(running), 16'h0);
    start = 1'b1; step();
    tick = 1'b1; step();
    tick = 1'b1; step();
    chk("tick2_count", 16'(count), 16'h03);
    pause = 1'b1; tick = 1'b1; step();
    chk("pause_tick_count", 16'(count), 16'h03);
    chk("pause_tick_running", 16'(running), 16'h0);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1; step();
    end
    chk("paused_ticks_count", 16'(count), 16'h03);
    start = 1'b1; pause = 1'b1; step();
    chk("start_pause_running", 16'(running), 16'h0);
    start = 1'b1; step();
    chk("resume_running", 16'(running), 16'h1);
    tick = 1'b1; step();
    chk("res_t1", 16'(count), 16'h02);
    tick = 1'b1; step();
    chk("res_t2", 16'(count), 16'h01);
    chk("res_t2_done", 16'(done), 16'h0);
    tick = 1'b1; step();
    chk("res_t3", 16'(count), 16'h00);
    chk("res_t3_done", 16'(done), 16'h1);
    chk("res_t3_running", 16'(running), 16'h0);
    step();
    chk("res_done_drop", 16'(done), 16'h0);

    // illegal load in DONE
    load = 1'b1; load_val = 8'h3A; step();
    chk("bad_load_err", 16'(load_err), 16'h1);
    chk("bad_load_count", 16'(count), 16'h00);
    step();
    chk("bad_load_err_drop", 16'(load_err), 16'h0);
    start = 1'b1; step();
    chk("done_start_ignored", 16'(running), 16'h0);

    // DONE -> IDLE on load, then clear beats load
    load = 1'b1; load_val = 8'h02; step();
    chk("done_load02", 16'(count), 16'h02);
    clear = 1'b1; load = 1'b1; load_val = 8'h40; step();
    chk("clear_wins_count", 16'(count), 16'h00);
    chk("clear_wins_running", 16'(running), 16'h0);
    start = 1'b1; step();
    chk("idle_zero_start", 16'(running), 16'h0);
    chk("idle_zero_done", 16'(done), 16'h0);

    // asynchronous reset mid-count
    load = 1'b1; load_val = 8'h17; step();
    start = 1'b1; step();
    chk("pre_reset_count", 16'(count), 16'h17);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_count", 16'(count), 16'h00);
    chk("async_rst_zero", 16'(zero), 16'h1);
    chk("async_rst_running", 16'(running), 16'h0);
    #2 reset = 1'b1;
    step();
    chk("post_rst_running", 16'(running), 16'h0);
    chk("post_rst_count", 16'(count), 16'h00);

    // 3-digit borrow: 100 -> 099
    load3 = 1'b1; load_val3 = 12'h100; step();
    chk("d3_load", 16'(count3), 16'h100);
    start3 = 1'b1; step();
    tick3 = 1'b1; step();
    chk("d3_borrow", 16'(count3), 16'h099);
    chk("d3_running", 16'(running3), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter_timer.md
Name: bcd_down_counter_timer

Overview:
- Multi-digit BCD countdown timer: loads a decimal preset, then counts down one unit per qualified tick, with borrow rippling across digits (0 -> 9 per digit).
- Stops at 00..0 and flags completion.
- Counterpart to the ascending mod-10 digit counters already used in the display path. Provides countdown timing (e.g. a seconds timer) feeding the same 7-segment decode chain.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS bits, digit 0 is least significant (bits [3:0]).

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear to zero and IDLE
load  input  1  load request for load_val
load_val  input  4*DIGITS  BCD preset value
start  input  1  start/resume request
pause  input  1  pause request
tick  input  1  one-cycle count enable from an external prescaler
count  output  4*DIGITS  current BCD value
running  output  1  high while state is RUN
zero  output  1  high when count is all zero
done  output  1  one-cycle pulse on reaching zero
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- reset low (asynchronous, any time, including mid-count):
  - count = 0, state = IDLE.
  - running = 0, zero = 1, done = 0, load_err = 0.
- All other changes occur on the rising clk edge. Outputs are registered or decoded directly from registers. zero is combinational from count.
- States and transitions:
  - IDLE: start with count != 0 -> RUN. start with count == 0 is ignored.
  - RUN: pause -> PAUSED. Decrement on tick. Reaching zero -> DONE.
  - PAUSED: start -> RUN. Ticks are ignored.
  - DONE: start is ignored. A valid load -> IDLE.
- Input priority, highest first, evaluated per cycle: clear, load, pause, start, tick.
  - clear: count = 0, state -> IDLE, done/load_err not asserted. Allowed in any state.
  - load: accepted in IDLE, PAUSED and DONE; ignored in RUN with no error.
    - If load_val contains any digit > 9: count is unchanged, state is unchanged, and load_err pulses high next cycle.
    - Otherwise count = load_val on the next edge. A load in PAUSED stays in PAUSED; a load in DONE goes to IDLE.
  - pause and start in the same cycle: pause wins. A tick in the same cycle as pause is not counted.
  - start in the same cycle as tick while IDLE/PAUSED: the state changes only; the first decrement happens on the next tick.
- Decrement rule (RUN and tick):
  - Digit 0 decrements by 1. A digit at 0 becomes 9 and borrows into the next digit. The borrow chain stops at the first nonzero digit.
  - Example: 10 -> 09, 100 -> 099.
  - There is no wrap below zero: the tick where count goes from 1 to 0 also sets state to DONE.
  - done is high for exactly the one cycle in which count first reads 0 and running first reads 0 (same edge).
- Ticks seen in DONE, IDLE or PAUSED never change count.
- running is high exactly while state is RUN.
- done and load_err are never high for more than one consecutive cycle.
- Digits must always hold values 0..9. Any illegal digit value is a design error and is covered by an assertion in the bench.

Test Plan:
- Reset, then load 0x25 in IDLE -> count = 0x25, zero = 0, running = 0.
  - start, then 25 ticks -> count steps 24, 23, …, 10, 09, …, 01, 00.
  - done pulses once when count = 00. State is DONE, running = 0. Extra ticks keep count at 00.
- load 0x10, start, 1 tick -> count = 0x09 (borrow across digits). With DIGITS=3: load 0x100, 1 tick -> 0x099.
- load 0x05, start, 2 ticks -> 0x03; pause + tick same cycle -> count stays 0x03, running = 0.
  - 3 further ticks -> still 0x03.
  - start + pause same cycle -> stays PAUSED.
  - start -> RUN; 3 ticks -> 0x00 with done pulse.
- load 0x3A -> load_err pulse, count unchanged. load while RUN -> ignored, no load_err. start with count 0x00 in IDLE -> stays IDLE, no done.
- Assert reset low asynchronously mid-count at 0x17 (between clock edges) -> count = 0 immediately, zero = 1, running = 0. Release reset -> IDLE.
- In DONE: load 0x02 -> IDLE. clear asserted together with load 0x40 -> count = 0x00, IDLE (clear wins).
